axi_mem_word_rd_slave: RTL
==========================

Name: axi_mem_word_rd_slave

Overview:
- AXI4 read-channel responder (AR in, R out) that serves read bursts from a simple word-addressed memory port (req/gnt then rvalid).
- Slave-side counterpart to the single-word AXI read initiators in the user plugin; lets plugin-local memories sit on the AXI interconnect.
- One memory access outstanding at a time.
- 32-bit beats only; unsupported requests are answered with SLVERR beats.

Parameters:
AXI4_ADDR_WIDTH, 32, AXI byte address width
AXI4_DATA_WIDTH, 32, data width (must be 32)
AXI4_ID_WIDTH, 16, ARID/RID width
AXI4_USER_WIDTH, 10, ARUSER/RUSER width

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ARID_i  in  ID  request ID
ARADDR_i  in  ADDR  byte start address
ARLEN_i  in  8  beats minus 1
ARSIZE_i  in  3  beat size
ARBURST_i  in  2  burst type
ARLOCK_i/ARCACHE_i/ARPROT_i/ARREGION_i/ARQOS_i/ARUSER_i  in  1/4/3/4/4/USER  accepted, ignored
ARVALID_i  in  1  address valid
ARREADY_o  out  1  address ready
RID_o  out  ID  echoed ARID
RDATA_o  out  DATA  read data
RRESP_o  out  2  OKAY/SLVERR
RLAST_o  out  1  final beat
RUSER_o  out  USER  always 0
RVALID_o  out  1  data valid
RREADY_i  in  1  data ready
mem_req_o  out  1  memory request
mem_word_addr_o  out  ADDR-2  word address (ARADDR>>2)
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory data valid, ≥1 cycle after grant
mem_rdata_i  in  DATA  memory data

Behaviour:
- Interface clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: ARREADY_o=0, RVALID_o=0, RLAST_o=0, RRESP_o=0, RDATA_o=0, RID_o=0, mem_req_o=0, mem_word_addr_o=0, state IDLE.
- All AXI and memory outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- States:
  - IDLE: ARREADY_o=1. On ARVALID_i, latch ID, address, len and burst, clear beat_cnt and set err = (ARSIZE_i!=2) or (ARBURST_i==2'b11). Next state is ERR if err, else REQ.
  - REQ: mem_req_o=1 with the current word address, held stable. On mem_gnt_i, go to WAIT.
  - WAIT: on mem_rvalid_i, capture mem_rdata_i into RDATA_o, RRESP_o=OKAY, go to RESP. mem_rvalid_i is ignored in every other state.
  - ERR: load RDATA_o=0, RRESP_o=SLVERR, go to RESP. No memory access is made.
  - RESP: RVALID_o=1 and RLAST_o=(beat_cnt==len). RDATA_o, RRESP_o and RLAST_o are held until RREADY_i.
    - On handshake with last beat: go to IDLE.
    - Otherwise: beat_cnt++, advance the address, and go to REQ (or ERR if err).
- Latency, single beat with immediate grant:
  - Cycle 0: AR handshake.
  - Cycle 1: mem_req_o, gnt.
  - Cycle 2: mem_rvalid_i.
  - Cycle 3: RVALID_o.
  - Earliest next ARREADY_o is the cycle after the R handshake. Throughput is 3 cycles per beat when there are no stalls.
- Address advance per burst type:
  - FIXED (00): unchanged.
  - INCR (01): +4, wrapping modulo 2^ADDR (no 4 KB check).
  - WRAP (10): see Optional Feature.
- Error bursts return exactly len+1 beats, each with SLVERR, RDATA 0 and correct RLAST.
- ARREADY_o is 0 in every state except IDLE. No new AR is accepted until the final R handshake.
- Reset asserted mid-burst: immediately return to IDLE with all outputs at reset values. The burst is abandoned without RLAST; the memory shares the same reset.

Optional Feature:
- Macro: AXI_MEM_WORD_RD_SLAVE_WRAP_EN.
- Defined:
  - WRAP with len in {1,3,7,15} is legal.
  - Next address = (addr & ~mask) | ((addr+4) & mask), where mask = ((len+1)*4)-1.
  - WRAP with any other len sets err, giving SLVERR beats.
- Undefined: any WRAP request sets err and is answered with len+1 SLVERR beats.

Decomposition:
- Package axi_word_pkg holds:
  - resp constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - burst constants BURST_FIXED/INCR/WRAP;
  - state enum rd_slv_state_t (IDLE, REQ, WAIT, ERR, RESP);
  - SIZE_WORD=3'd2.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, burst). The WRAP arm is under the macro.

Test Plan:
- Single read: ARADDR=0x100, LEN=0, SIZE=2, INCR, ID=0x5; memory returns 0xDEADBEEF -> mem_word_addr_o=0x40; one beat RDATA=0xDEADBEEF, RRESP=OKAY, RLAST=1, RID=0x5; RVALID 3 cycles after AR.
- INCR burst: ARADDR=0x200, LEN=3 -> word addresses 0x80,0x81,0x82,0x83; RLAST only on beat 4; ARREADY low throughout.
- Backpressure and grant stall: RREADY low for 5 cycles, mem_gnt_i delayed 2 cycles -> RDATA/RLAST stable while stalled; mem_req_o and address held until grant; no beat lost or duplicated.
- Error: ARSIZE=1, LEN=2 -> 3 beats of SLVERR, RDATA=0, RLAST on beat 3; mem_req_o never asserted.
- WRAP (macro on): ARADDR=0x38, LEN=3 -> word addresses 0x0E,0x0F,0x0C,0x0D. Macro off: same request -> 4 SLVERR beats.
- Reset mid-burst: assert ARESET during beat 2 of LEN=7 -> RVALID_o, mem_req_o drop asynchronously; after release ARREADY_o=1 and a new LEN=0 read completes normally.

Source files
------------

// File: rtl/axi_word_pkg.sv
// Shared AXI4 read-channel constants, state encoding and helpers for
// axi_mem_word_rd_slave and its burst address generator.
package axi_word_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    ERR,
    RESP
  } rd_slv_state_t;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts of
// 32-bit beats. WRAP support is built only when AXI_MEM_WORD_RD_SLAVE_WRAP_EN
// is defined; otherwise a WRAP burst never reaches memory, so its address is
// simply held.
module axi_burst_addr_gen
  import axi_word_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_addr_o
);

  logic [AW-1:0] incr_addr;
  assign incr_addr = addr_i + AW'(4);

`ifdef AXI_MEM_WORD_RD_SLAVE_WRAP_EN
  logic [AW-1:0] wrap_mask;
  // Burst footprint in bytes minus one; a power of two minus one for legal lens.
  assign wrap_mask = ((AW'(len_i) + AW'(1)) << 2) - AW'(1);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  // Select the advance rule for the latched burst type.
  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
`ifdef AXI_MEM_WORD_RD_SLAVE_WRAP_EN
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_mem_word_rd_slave.sv
// AXI4 read responder serving bursts from a req/gnt/rvalid word memory.
// One memory access outstanding; every output comes from registers or state.
// Optional WRAP burst support: define AXI_MEM_WORD_RD_SLAVE_WRAP_EN.
module axi_mem_word_rd_slave
  import axi_word_pkg::*;
#(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI4_ID_WIDTH-1:0]   ARID_i,
  input  logic [AXI4_ADDR_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                 ARLEN_i,
  input  logic [2:0]                 ARSIZE_i,
  input  logic [1:0]                 ARBURST_i,
  input  logic                       ARLOCK_i,
  input  logic [3:0]                 ARCACHE_i,
  input  logic [2:0]                 ARPROT_i,
  input  logic [3:0]                 ARREGION_i,
  input  logic [3:0]                 ARQOS_i,
  input  logic [AXI4_USER_WIDTH-1:0] ARUSER_i,
  input  logic                       ARVALID_i,
  output logic                       ARREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]   RID_o,
  output logic [AXI4_DATA_WIDTH-1:0] RDATA_o,
  output logic [1:0]                 RRESP_o,
  output logic                       RLAST_o,
  output logic [AXI4_USER_WIDTH-1:0] RUSER_o,
  output logic                       RVALID_o,
  input  logic                       RREADY_i,
  output logic                       mem_req_o,
  output logic [AXI4_ADDR_WIDTH-3:0] mem_word_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [AXI4_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int AW = AXI4_ADDR_WIDTH;

  rd_slv_state_t state_q, state_d;
  logic [AXI4_ID_WIDTH-1:0]   id_q, id_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [7:0]                 len_q, len_d;
  logic [1:0]                 burst_q, burst_d;
  logic [7:0]                 beat_q, beat_d;
  logic                       err_q, err_d;
  logic [AXI4_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic                       arready_q, arready_d;
  logic [AW-1:0]              next_addr;
  logic                       ar_err;
  logic                       last_beat;

  logic unused_inputs;
  assign unused_inputs = ^{ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i, ARUSER_i};

  axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Classify an incoming request as unsupported (answered with SLVERR beats).
  always_comb begin
    ar_err = (ARSIZE_i != SIZE_WORD) || (ARBURST_i == 2'b11);
`ifdef AXI_MEM_WORD_RD_SLAVE_WRAP_EN
    if ((ARBURST_i == BURST_WRAP) && !wrap_len_ok(ARLEN_i)) ar_err = 1'b1;
`else
    if (ARBURST_i == BURST_WRAP) ar_err = 1'b1;
`endif
  end

  assign last_beat = (beat_q == len_q);

  // Next-state and datapath-load decode.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        // arready_q gates acceptance so the handshake matches what the master sees.
        if (ARVALID_i && arready_q) begin
          id_d    = ARID_i;
          addr_d  = ARADDR_i;
          len_d   = ARLEN_i;
          burst_d = ARBURST_i;
          beat_d  = 8'd0;
          err_d   = ar_err;
          state_d = ar_err ? ERR : REQ;
        end
      end
      REQ: if (mem_gnt_i) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          rresp_d = RESP_OKAY;
          state_d = RESP;
        end
      end
      ERR: begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        state_d = RESP;
      end
      RESP: begin
        if (RREADY_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = err_q ? ERR : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  // State and datapath registers; async reset abandons any burst in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
    end
  end

  assign ARREADY_o       = arready_q;
  assign RVALID_o        = (state_q == RESP);
  assign RLAST_o         = (state_q == RESP) && last_beat;
  assign RDATA_o         = rdata_q;
  assign RRESP_o         = rresp_q;
  assign RID_o           = id_q;
  assign RUSER_o         = '0;
  assign mem_req_o       = (state_q == REQ);
  assign mem_word_addr_o = addr_q[AW-1:2];

endmodule
